// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the FIR filter. It loads coefficients through the
// address generator, gathers input samples, runs one MAC pass per output, waits
// for the accumulator pipeline to settle and then presents the result. It supports
// decimation and interpolation at a rate of 2^cur_dec_level. Every output is a
// combinational decode of the current state and the handshake inputs.
module fir_sequencer #(
    parameter int FS_WIDTH    = 6,
    parameter int MAC_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_init,
    input  logic       coeff_valid,
    output logic       coeff_ready,
    output logic       coeff_we,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       shift_en,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       downsample,
    input  logic [1:0] cur_dec_level,
    input  logic       last_coeff,
    input  logic       batch_first_data,
    output logic       incr_addr,
    output logic       reset_counter,
    output logic       init_in_progress,
    output logic       addr_downsample,
    output logic       acc_clear,
    output logic       acc_en,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_GATHER = 3'd2,
        S_MAC    = 3'd3,
        S_DRAIN  = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    // DRAIN runs for MAC_LATENCY cycles: it is loaded with MAC_LATENCY-1 and
    // leaves once the count has reached zero.
    localparam logic [3:0] DRAIN_LOAD = 4'(MAC_LATENCY - 1);

    if (FS_WIDTH < 1 || MAC_LATENCY < 1 || MAC_LATENCY > 15) begin : g_bad_params
        $error("fir_sequencer: FS_WIDTH must be >= 1 and MAC_LATENCY within 1..15");
    end

    state_t     state_q, state_d;
    logic       coeffs_loaded_q, coeffs_loaded_d;
    logic [2:0] phase_cnt_q, phase_cnt_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [2:0] phase_last;

    // Last phase index of a group: 2^L - 1 (decimation inputs or interpolation outputs).
    assign phase_last = 3'((4'd1 << cur_dec_level) - 4'd1);

    // The address generator must count unscaled while coefficients are written.
    assign addr_downsample = downsample | init_in_progress;

    assign busy = (state_q != S_IDLE);

    // State and counter registers; an asynchronous reset forces re-initialisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            coeffs_loaded_q <= 1'b0;
            phase_cnt_q     <= 3'd0;
            drain_cnt_q     <= 4'd0;
        end else begin
            state_q         <= state_d;
            coeffs_loaded_q <= coeffs_loaded_d;
            phase_cnt_q     <= phase_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d          = state_q;
        coeffs_loaded_d  = coeffs_loaded_q;
        phase_cnt_d      = phase_cnt_q;
        drain_cnt_d      = drain_cnt_q;
        coeff_ready      = 1'b0;
        coeff_we         = 1'b0;
        in_ready         = 1'b0;
        shift_en         = 1'b0;
        out_valid        = 1'b0;
        incr_addr        = 1'b0;
        reset_counter    = 1'b0;
        init_in_progress = 1'b0;
        acc_clear        = 1'b0;
        acc_en           = 1'b0;

        case (state_q)
            S_IDLE: begin
                reset_counter = 1'b1;
                if (start_init) begin
                    state_d = S_INIT;
                end else if (coeffs_loaded_q) begin
                    state_d     = S_GATHER;
                    phase_cnt_d = 3'd0;
                end
            end

            S_INIT: begin
                init_in_progress = 1'b1;
                coeff_ready      = 1'b1;
                if (coeff_valid) begin
                    coeff_we  = 1'b1;
                    incr_addr = 1'b1;
                    if (last_coeff) begin
                        coeffs_loaded_d = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end

            S_GATHER: begin
                reset_counter = 1'b1;
                in_ready      = 1'b1;
                if (in_valid) begin
                    shift_en = 1'b1;
                    if (!downsample || phase_cnt_q == phase_last) begin
                        state_d     = S_MAC;
                        phase_cnt_d = 3'd0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 3'd1;
                    end
                end
            end

            S_MAC: begin
                incr_addr = 1'b1;
                acc_en    = 1'b1;
                acc_clear = batch_first_data;
                if (last_coeff) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end

            S_DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d = S_OUT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end

            S_OUT: begin
                out_valid     = 1'b1;
                reset_counter = 1'b1;
                if (out_ready) begin
                    if (!downsample && phase_cnt_q < phase_last) begin
                        state_d     = S_MAC;
                        phase_cnt_d = phase_cnt_q + 3'd1;
                    end else begin
                        state_d     = S_GATHER;
                        phase_cnt_d = 3'd0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: an address-generator stand-in closes the loop, a
// transaction-level model predicts all outputs each cycle, and directed scenarios
// pin strobe counts and latencies with literal values.
`timescale 1ns/1ps
module tb_fir_sequencer;
    localparam int ML = 2;

    localparam int P_IDLE   = 0;
    localparam int P_INIT   = 1;
    localparam int P_GATHER = 2;
    localparam int P_MAC    = 3;
    localparam int P_DRAIN  = 4;
    localparam int P_OUT    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_init, coeff_valid, in_valid, out_ready, downsample;
    logic [1:0] cur_dec_level;
    logic       coeff_ready, coeff_we, in_ready, shift_en, out_valid, incr_addr;
    logic       reset_counter, init_in_progress, addr_downsample, acc_clear, acc_en, busy;
    logic       last_coeff, batch_first_data;

    int fs;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fir_sequencer #(.FS_WIDTH(6), .MAC_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .start_init(start_init), .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready), .coeff_we(coeff_we),
        .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .downsample(downsample), .cur_dec_level(cur_dec_level),
        .last_coeff(last_coeff), .batch_first_data(batch_first_data),
        .incr_addr(incr_addr), .reset_counter(reset_counter),
        .init_in_progress(init_in_progress), .addr_downsample(addr_downsample),
        .acc_clear(acc_clear), .acc_en(acc_en), .busy(busy)
    );

    // Address generator stand-in: a pass ends after fs+1 steps when unscaled,
    // after (fs+1)<<L steps when interpolating.
    logic [7:0] ag_addr;
    int         ag_limit;
    always @(posedge clk or posedge rst) begin
        if (rst)                ag_addr <= 8'd0;
        else if (reset_counter) ag_addr <= 8'd0;
        else if (incr_addr)     ag_addr <= ag_addr + 8'd1;
    end
    always_comb begin
        ag_limit = fs;
        if (!addr_downsample) ag_limit = ((fs + 1) << cur_dec_level) - 1;
    end
    assign last_coeff       = (int'(ag_addr) == ag_limit);
    assign batch_first_data = (ag_addr == 8'd0);

    // Transaction model: phase plus a count of words/samples/MAC steps/drain cycles.
    int   m_ph, m_cnt, m_outs, n_ph, n_cnt, n_outs;
    logic m_loaded, n_loaded;
    always_comb begin
        n_ph = m_ph; n_cnt = m_cnt; n_outs = m_outs; n_loaded = m_loaded;
        case (m_ph)
            P_IDLE: begin
                if (start_init) begin
                    n_ph = P_INIT; n_cnt = 0;
                end else if (m_loaded) begin
                    n_ph = P_GATHER; n_cnt = 0; n_outs = 0;
                end
            end
            P_INIT: begin
                if (coeff_valid) begin
                    n_cnt = m_cnt + 1;
                    if (n_cnt == fs + 1) begin n_loaded = 1'b1; n_ph = P_IDLE; end
                end
            end
            P_GATHER: begin
                if (in_valid) begin
                    n_cnt = m_cnt + 1;
                    if (n_cnt == (downsample ? (1 << cur_dec_level) : 1)) begin
                        n_ph = P_MAC; n_cnt = 0;
                    end
                end
            end
            P_MAC: begin
                n_cnt = m_cnt + 1;
                if (n_cnt == (downsample ? fs + 1 : (fs + 1) << cur_dec_level)) begin
                    n_ph = P_DRAIN; n_cnt = 0;
                end
            end
            P_DRAIN: begin
                n_cnt = m_cnt + 1;
                if (n_cnt == ML) begin n_ph = P_OUT; n_cnt = 0; end
            end
            P_OUT: begin
                if (out_ready) begin
                    n_outs = m_outs + 1;
                    if (!downsample && n_outs < (1 << cur_dec_level)) begin
                        n_ph = P_MAC; n_cnt = 0;
                    end else begin
                        n_ph = P_GATHER; n_cnt = 0; n_outs = 0;
                    end
                end
            end
            default: ;
        endcase
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_IDLE; m_cnt <= 0; m_outs <= 0; m_loaded <= 1'b0;
        end else begin
            m_ph <= n_ph; m_cnt <= n_cnt; m_outs <= n_outs; m_loaded <= n_loaded;
        end
    end

    // {coeff_ready, coeff_we, in_ready, shift_en, out_valid, incr_addr,
    //  reset_counter, init_in_progress, addr_downsample, acc_clear, acc_en, busy}
    function automatic logic [11:0] model_expect();
        logic [11:0] e;
        e = '0;
        e[3] = downsample;
        case (m_ph)
            P_IDLE:   e[5] = 1'b1;
            P_INIT:   begin e[11] = 1'b1; e[10] = coeff_valid; e[6] = coeff_valid;
                            e[4] = 1'b1; e[3] = 1'b1; e[0] = 1'b1; end
            P_GATHER: begin e[9] = 1'b1; e[8] = in_valid; e[5] = 1'b1; e[0] = 1'b1; end
            P_MAC:    begin e[6] = 1'b1; e[1] = 1'b1; e[2] = (m_cnt == 0); e[0] = 1'b1; end
            P_DRAIN:  e[0] = 1'b1;
            P_OUT:    begin e[7] = 1'b1; e[5] = 1'b1; e[0] = 1'b1; end
            default:  e = '1;
        endcase
        return e;
    endfunction

    int cyc, mac_cnt, clr_cnt, we_cnt, shift_cnt, ofire_cnt, incr_cnt, inrdy_cnt;
    int ov_cnt, init_cnt, last_acc, ov_rise;
    logic prev_ov;

    task automatic clear_tallies();
        mac_cnt = 0; clr_cnt = 0; we_cnt = 0; shift_cnt = 0; ofire_cnt = 0;
        incr_cnt = 0; inrdy_cnt = 0; ov_cnt = 0; init_cnt = 0; last_acc = 0; ov_rise = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model at the falling edge, plus strobe tallies.
    task automatic tick();
        logic [11:0] a, e;
        @(negedge clk);
        e = model_expect();
        a = {coeff_ready, coeff_we, in_ready, shift_en, out_valid, incr_addr,
             reset_counter, init_in_progress, addr_downsample, acc_clear, acc_en, busy};
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL cycle %0d outputs (model phase %0d): actual=%b required=%b",
                     cyc, m_ph, a, e);
        end
        cyc++;
        if (acc_en) begin mac_cnt++; last_acc = cyc; end
        if (acc_clear) clr_cnt++;
        if (coeff_we) we_cnt++;
        if (shift_en) shift_cnt++;
        if (out_valid && out_ready) ofire_cnt++;
        if (incr_addr) incr_cnt++;
        if (in_ready) inrdy_cnt++;
        if (out_valid) ov_cnt++;
        if (init_in_progress) init_cnt++;
        if (out_valid && !prev_ov) ov_rise = cyc;
        prev_ov = out_valid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] pat;
        int n, snap_incr, snap_inr, snap_ov;
        rst = 1'b1; start_init = 1'b0; coeff_valid = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; downsample = 1'b0; cur_dec_level = 2'd0; fs = 7;
        cyc = 0; prev_ov = 1'b0;
        clear_tallies();
        repeat (3) tick();
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset reset_counter", reset_counter, 1);

        // Not yet initialised: samples are refused.
        in_valid = 1'b1;
        repeat (3) tick();
        check("uninit in_ready", in_ready, 0);

        // Coefficient load, filter_size=7, with gaps; samples offered meanwhile.
        downsample = 1'b1; cur_dec_level = 2'd2;
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        clear_tallies();
        pat = 12'b1101_1100_1101;
        for (int i = 0; i < 12; i++) begin
            coeff_valid = pat[i];
            tick();
        end
        coeff_valid = 1'b0; in_valid = 1'b0;
        check("init coeff_we pulses", we_cnt, 8);
        check("init cycles", init_cnt, 12);
        check("init in_ready cycles", inrdy_cnt, 0);
        check("after init busy", busy, 0);
        tick();
        check("gather in_ready", in_ready, 1);

        // start_init outside IDLE is ignored.
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        check("ignored start_init", init_in_progress, 0);
        check("still gather", in_ready, 1);

        // Decimate L=2, filter_size=7: 4 samples -> 8 MAC cycles -> one result.
        clear_tallies();
        pat = 12'b0000_0001_1011;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i];
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("decim out_valid wait", out_valid, 1);
        tick(); tick();
        check("decim samples", shift_cnt, 4);
        check("decim mac cycles", mac_cnt, 8);
        check("decim acc_clear", clr_cnt, 1);
        check("decim outputs", ofire_cnt, 1);
        check("decim out latency", ov_rise - last_acc, ML + 1);

        // Interpolate L=1, filter_size=3, first result stalled 10 cycles.
        downsample = 1'b0; cur_dec_level = 2'd1; fs = 3; out_ready = 1'b0;
        clear_tallies();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("interp out_valid wait", out_valid, 1);
        snap_incr = incr_cnt; snap_inr = inrdy_cnt; snap_ov = ov_cnt;
        repeat (10) tick();
        check("stall out_valid", out_valid, 1);
        check("stall incr_addr", incr_cnt - snap_incr, 0);
        check("stall in_ready", inrdy_cnt - snap_inr, 0);
        check("stall out_valid cycles", ov_cnt - snap_ov, 10);
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin tick(); n++; end
        check("interp return to gather", in_ready, 1);
        tick();
        check("interp mac cycles", mac_cnt, 16);
        check("interp acc_clear", clr_cnt, 2);
        check("interp outputs", ofire_cnt, 2);
        check("interp samples", shift_cnt, 1);
        check("interp in_ready cycles", inrdy_cnt, 2);

        // Asynchronous reset in the middle of a MAC pass (decimate L=1).
        downsample = 1'b1; cur_dec_level = 2'd1;
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check("mac entered", acc_en, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst acc_en", acc_en, 0);
        check("rst incr_addr", incr_addr, 0);
        check("rst busy", busy, 0);
        check("rst reset_counter", reset_counter, 1);
        check("rst out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        clear_tallies();
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        check("post-rst in_ready cycles", inrdy_cnt, 0);
        check("post-rst busy", busy, 0);

        // Re-initialise with filter_size=3, then L=0 in both modes.
        clear_tallies();
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        coeff_valid = 1'b1;
        n = 0;
        while (init_in_progress && n < 20) begin tick(); n++; end
        coeff_valid = 1'b0;
        check("reinit coeff_we pulses", we_cnt, 4);
        tick();
        for (int mode = 1; mode >= 0; mode--) begin
            downsample = (mode == 1); cur_dec_level = 2'd0;
            clear_tallies();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 30) begin tick(); n++; end
            check("L0 out_valid wait", out_valid, 1);
            tick(); tick();
            check("L0 mac cycles", mac_cnt, 4);
            check("L0 outputs", ofire_cnt, 1);
            check("L0 samples", shift_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
